// File: rtl/spart_pkg.sv
// Shared types and helpers for the oversampling serial receiver.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Two-out-of-three vote used to decide each received bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity (XOR reduction) over up to 9 data bits; callers zero-extend.
  function automatic logic parity9(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Small show-ahead receive FIFO.
// Handshake: push writes din when not full, or when full and a pop happens in
// the same cycle (pop is taken first). pop removes the head only when not
// empty; a pop on an empty FIFO is ignored. dout is the head, 0 when empty.
module spart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spart_rx_multi.sv
// Configurable oversampling serial receiver with majority-vote bit decisions,
// optional parity, 1 or 2 stop bits, break handling and a receive FIFO.
module spart_rx_multi
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 brg_en,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] DATABUS,
  output logic                 RDA,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output rx_state_t            dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = (STOP_BITS == 2);
  localparam logic          ODD    = (PARITY_ODD != 0);

  rx_state_t            state;
  logic                 rx_meta, rx_sync;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data;
  logic                 push_perr;
  logic                 frame_set;
  logic                 fifo_full, fifo_empty;
  logic                 bit_val;

  assign bit_val   = maj3(samp[0], samp[1], rx_sync);
  assign dbg_state = state;
  assign RDA       = ~fifo_empty;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // Frame FSM: every decision is taken on an oversample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      samp      <= 2'b11;
      shift_reg <= '0;
      par_bad   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      push_perr <= 1'b0;
      frame_set <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_set <= 1'b0;
      if (brg_en) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          BREAK: begin
            if (rx_sync) state <= IDLE;
          end
          default: begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == T_S0) samp[0] <= rx_sync;
            if (tick_cnt == T_S1) samp[1] <= rx_sync;
            case (state)
              START: begin
                if (tick_cnt == T_S2 && bit_val) begin
                  state    <= IDLE;
                  tick_cnt <= '0;
                end
                if (tick_cnt == T_LAST) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
              end
              DATA: begin
                if (tick_cnt == T_S2) shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                if (tick_cnt == T_LAST) begin
                  stop_cnt <= 1'b0;
                  if (bit_cnt == B_LAST) begin
                    bit_cnt <= '0;
                    state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                  end
                end
              end
              PARITY: begin
                if (tick_cnt == T_S2)
                  par_bad <= bit_val != (parity9(9'(shift_reg)) ^ ODD);
                if (tick_cnt == T_LAST) state <= STOP;
              end
              STOP: begin
                if (tick_cnt == T_S2) begin
                  if (!bit_val) begin
                    frame_set <= 1'b1;
                    state     <= rx_sync ? IDLE : BREAK;
                    tick_cnt  <= '0;
                  end else if (stop_cnt == S_LAST) begin
                    push_q    <= 1'b1;
                    push_data <= shift_reg;
                    push_perr <= (PARITY_EN != 0) & par_bad;
                    state     <= IDLE;
                    tick_cnt  <= '0;
                  end
                end
                if (tick_cnt == T_LAST) stop_cnt <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        endcase
      end
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_set)              frame_err <= 1'b1;
      else if (err_clr)           frame_err <= 1'b0;
      if (push_q && push_perr)    parity_err <= 1'b1;
      else if (err_clr)           parity_err <= 1'b0;
      if (push_q && fifo_full && !clr_rda) overrun <= 1'b1;
      else if (err_clr)           overrun <= 1'b0;
    end
  end

  spart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_q),
    .din  (push_data),
    .pop  (clr_rda),
    .dout (DATABUS),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_spart_rx_multi.sv
// Directed bench for spart_rx_multi: an 8N1 instance and an 8E1 instance.
module tb_spart_rx_multi;
  import spart_pkg::*;

  localparam int CPB = 64;  // clocks per bit: 16 ticks x 4 clocks

  // ---------------- clock / reset / tick ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       brg_en = 1'b0;
  logic [1:0] div = 2'd0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div    = div + 2'd1;
    brg_en = (div == 2'd0);
  end

  // ---------------- DUT signals ----------------
  logic       rx_a, rx_b, clr_a, clr_b, err_clr_a, err_clr_b;
  logic [7:0] data_a, data_b;
  logic       rda_a, rda_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  rx_state_t  st_a, st_b;

  spart_rx_multi dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .brg_en(brg_en), .clr_rda(clr_a),
    .DATABUS(data_a), .RDA(rda_a), .err_clr(err_clr_a), .frame_err(fe_a),
    .parity_err(pe_a), .overrun(ov_a), .dbg_state(st_a)
  );

  spart_rx_multi #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_b), .brg_en(brg_en), .clr_rda(clr_b),
    .DATABUS(data_b), .RDA(rda_b), .err_clr(err_clr_b), .frame_err(fe_b),
    .parity_err(pe_b), .overrun(ov_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bit_time(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic send_body(input bit which, input logic [7:0] d, input bit par_en, input logic par_bit);
    drive(which, 1'b0);
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      bit_time(1);
    end
    if (par_en) begin
      drive(which, par_bit);
      bit_time(1);
    end
  endtask

  task automatic send_char(input bit which, input logic [7:0] d, input bit par_en, input logic par_bit);
    send_body(which, d, par_en, par_bit);
    drive(which, 1'b1);
    bit_time(2);
  endtask

  task automatic pop_check(input bit which, input string tag);
    logic [7:0] e;
    if (which) begin
      e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 8'hxx;
      chk({tag, "_rda"}, 32'(rda_b), 32'd1);
      chk({tag, "_data"}, 32'(data_b), 32'(e));
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk({tag, "_rda"}, 32'(rda_a), 32'd1);
      chk({tag, "_data"}, 32'(data_a), 32'(e));
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
    end
  endtask

  task automatic pulse_err_clr_a();
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d;
    bit         got;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rda", 32'(rda_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_flags", {29'd0, fe_a, pe_a, ov_a}, 32'd0);
    chk("rst_state", 32'(st_a), 32'(IDLE));
    chk("rst_rda_b", 32'(rda_b), 32'd0);
    rst_n = 1'b1;
    bit_time(2);

    // Two back-to-back characters, popped in order.
    exp_q.push_back(8'h55); send_char(0, 8'h55, 0, 1'b0);
    exp_q.push_back(8'hA3); send_char(0, 8'hA3, 0, 1'b0);
    pop_check(0, "c1");
    pop_check(0, "c2");
    chk("c_rda_empty", 32'(rda_a), 32'd0);
    chk("c_data_empty", 32'(data_a), 32'd0);
    chk("c_flags", {29'd0, fe_a, pe_a, ov_a}, 32'd0);

    // Short low glitch must be rejected.
    drive(0, 1'b0);
    repeat (12) @(negedge clk);
    drive(0, 1'b1);
    bit_time(2);
    chk("glitch_state", 32'(st_a), 32'(IDLE));
    chk("glitch_rda", 32'(rda_a), 32'd0);
    chk("glitch_flags", {29'd0, fe_a, pe_a, ov_a}, 32'd0);

    // Even parity: 0x07 needs parity 1, send 0 -> pushed with parity_err.
    exp_b_q.push_back(8'h07); send_char(1, 8'h07, 1, 1'b0);
    chk("par_err", 32'(pe_b), 32'd1);
    chk("par_fe", 32'(fe_b), 32'd0);
    pop_check(1, "par");

    // Stop bit low then a long break.
    send_body(0, 8'h3C, 0, 1'b0);
    drive(0, 1'b0);
    bit_time(40);
    chk("brk_state", 32'(st_a), 32'(BREAK));
    chk("brk_fe", 32'(fe_a), 32'd1);
    chk("brk_rda", 32'(rda_a), 32'd0);
    drive(0, 1'b1);
    bit_time(1);
    chk("brk_exit", 32'(st_a), 32'(IDLE));
    chk("brk_fe_sticky", 32'(fe_a), 32'd1);
    pulse_err_clr_a();
    chk("brk_fe_clr", 32'(fe_a), 32'd0);
    exp_q.push_back(8'h5A); send_char(0, 8'h5A, 0, 1'b0);
    pop_check(0, "post_brk");
    chk("post_brk_rda", 32'(rda_a), 32'd0);

    // Five characters into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < 4) exp_q.push_back(d);
      send_char(0, d, 0, 1'b0);
    end
    chk("ovr_flag", 32'(ov_a), 32'd1);
    chk("ovr_head", 32'(data_a), 32'(exp_q[0]));
    pulse_err_clr_a();
    chk("ovr_clr", 32'(ov_a), 32'd0);

    // Push while full with a pop in the same cycle: no overrun.
    send_body(0, 8'h66, 0, 1'b0);
    drive(0, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 2 * CPB && !got; k++) begin
      @(negedge clk);
      if (dut_a.push_q) got = 1'b1;
    end
    chk("simul_push_seen", 32'(got), 32'd1);
    chk("simul_head", 32'(data_a), 32'(exp_q.pop_front()));
    clr_a = 1'b1;
    exp_q.push_back(8'h66);
    @(negedge clk);
    clr_a = 1'b0;
    bit_time(2);
    chk("simul_no_ovr", 32'(ov_a), 32'd0);
    for (int i = 0; i < 4; i++) pop_check(0, "drain");
    chk("drain_rda", 32'(rda_a), 32'd0);

    // Reset in the middle of a character.
    exp_q.push_back(8'h81); send_char(0, 8'h81, 0, 1'b0);
    chk("pre_rst_rda", 32'(rda_a), 32'd1);
    d = 8'hF0;
    drive(0, 1'b0);
    bit_time(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, d[i]);
      bit_time(1);
    end
    drive(0, d[3]);
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_rda", 32'(rda_a), 32'd0);
    chk("mid_rst_data", 32'(data_a), 32'd0);
    chk("mid_rst_state", 32'(st_a), 32'(IDLE));
    chk("mid_rst_pe_b", 32'(pe_b), 32'd0);
    drive(0, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    bit_time(12);
    chk("post_rst_rda", 32'(rda_a), 32'd0);
    chk("post_rst_flags", {29'd0, fe_a, pe_a, ov_a}, 32'd0);
    exp_q.push_back(8'h96); send_char(0, 8'h96, 0, 1'b0);
    pop_check(0, "post_rst");
    chk("post_rst_empty", 32'(rda_a), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size() + exp_b_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
